// File: rtl/fetch_pc_unit_if.sv
// Fetch next-PC unit bus: fetch-side lookup signals and EX-side resolution signals.
// The unit side is the slave; the pipeline/environment side is the master.
interface fetch_pc_unit_if;
    logic        i_stall;
    logic        i_bp_predict_taken;
    logic [31:0] o_fetch_pc;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        i_ex_valid_branch;
    logic [31:0] i_ex_pc;
    logic        i_ex_taken;
    logic [31:0] i_ex_target;
    logic        i_ex_pred_taken;
    logic [31:0] i_ex_pred_target;
    logic        o_redirect;
    logic [31:0] o_branch_count;
    logic [31:0] o_mispredict_count;

    modport master (
        output i_stall,
        output i_bp_predict_taken,
        input  o_fetch_pc,
        input  o_pred_taken,
        input  o_pred_target,
        output i_ex_valid_branch,
        output i_ex_pc,
        output i_ex_taken,
        output i_ex_target,
        output i_ex_pred_taken,
        output i_ex_pred_target,
        input  o_redirect,
        input  o_branch_count,
        input  o_mispredict_count
    );

    modport slave (
        input  i_stall,
        input  i_bp_predict_taken,
        output o_fetch_pc,
        output o_pred_taken,
        output o_pred_target,
        input  i_ex_valid_branch,
        input  i_ex_pc,
        input  i_ex_taken,
        input  i_ex_target,
        input  i_ex_pred_taken,
        input  i_ex_pred_target,
        output o_redirect,
        output o_branch_count,
        output o_mispredict_count
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch-stage next-PC generator: PC register, direct-mapped BTB lookup,
// EX-stage mispredict redirect and saturating branch/mispredict counters.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BTB_IDX_W = 4
) (
    input logic           clk,
    input logic           rst,
    fetch_pc_unit_if.slave bus
);
    localparam int ENTRIES = 1 << BTB_IDX_W;
    localparam int TAG_W   = 30 - BTB_IDX_W;

    logic [31:0]          pc;
    logic [31:0]          pc_plus4;
    logic [31:0]          next_pc;

    logic [ENTRIES-1:0]   btb_valid;
    logic [TAG_W-1:0]     btb_tag [ENTRIES];
    logic [29:0]          btb_target [ENTRIES];

    logic [BTB_IDX_W-1:0] lookup_idx;
    logic [TAG_W-1:0]     lookup_tag;
    logic                 hit;
    logic                 pred_taken;
    logic [31:0]          pred_target;

    logic [BTB_IDX_W-1:0] update_idx;
    logic [TAG_W-1:0]     update_tag;
    logic                 update_en;

    logic                 mispredict;
    logic [31:0]          ex_pc_plus4;
    logic [31:0]          correct_pc;

    logic [31:0]          branch_count;
    logic [31:0]          mispredict_count;

    assign lookup_idx = pc[BTB_IDX_W+1:2];
    assign lookup_tag = pc[31:BTB_IDX_W+2];
    assign pc_plus4   = pc + 32'd4;

    assign update_idx = bus.i_ex_pc[BTB_IDX_W+1:2];
    assign update_tag = bus.i_ex_pc[31:BTB_IDX_W+2];
    assign update_en  = bus.i_ex_valid_branch && bus.i_ex_taken;

    assign ex_pc_plus4 = bus.i_ex_pc + 32'd4;

    // BTB lookup and final prediction for the current fetch PC
    always_comb begin
        hit         = 1'b0;
        pred_taken  = 1'b0;
        pred_target = pc_plus4;
        if (btb_valid[lookup_idx] && (btb_tag[lookup_idx] == lookup_tag)) begin
            hit = 1'b1;
        end
        pred_taken = hit && bus.i_bp_predict_taken;
        if (pred_taken) begin
            pred_target = {btb_target[lookup_idx], 2'b00};
        end
    end

    // Mispredict detection and recovery PC from the EX-stage branch
    always_comb begin
        mispredict = 1'b0;
        correct_pc = ex_pc_plus4;
        if (bus.i_ex_valid_branch) begin
            if (bus.i_ex_taken != bus.i_ex_pred_taken) begin
                mispredict = 1'b1;
            end else if (bus.i_ex_taken &&
                         (bus.i_ex_target != bus.i_ex_pred_target)) begin
                mispredict = 1'b1;
            end
        end
        if (bus.i_ex_taken) begin
            correct_pc = bus.i_ex_target;
        end
    end

    // Next-PC select: redirect beats stall, stall beats prediction
    always_comb begin
        next_pc = pred_target;
        if (mispredict) begin
            next_pc = correct_pc;
        end else if (bus.i_stall) begin
            next_pc = pc;
        end
    end

    // PC register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    // BTB valid bits, cleared on reset and set by every taken branch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btb_valid <= '0;
        end else if (update_en) begin
            btb_valid[update_idx] <= 1'b1;
        end
    end

    // BTB tag/target storage, only meaningful where the valid bit is set
    always_ff @(posedge clk) begin
        if (update_en) begin
            btb_tag[update_idx]    <= update_tag;
            btb_target[update_idx] <= bus.i_ex_target[31:2];
        end
    end

    // Saturating resolved-branch and mispredict counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (bus.i_ex_valid_branch && (branch_count != 32'hFFFF_FFFF)) begin
                branch_count <= branch_count + 32'd1;
            end
            if (mispredict && (mispredict_count != 32'hFFFF_FFFF)) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
        end
    end

    assign bus.o_fetch_pc         = pc;
    assign bus.o_pred_taken       = pred_taken;
    assign bus.o_pred_target      = pred_target;
    assign bus.o_redirect         = mispredict;
    assign bus.o_branch_count     = branch_count;
    assign bus.o_mispredict_count = mispredict_count;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: directed cycles push expected outputs,
// a negedge monitor pops and compares them.
module tb_fetch_pc_unit;
    logic clk;
    logic rst;

    fetch_pc_unit_if bus ();

    fetch_pc_unit #(
        .RESET_PC  (32'h0000_0000),
        .BTB_IDX_W (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [3:0] M_PC  = 4'b0001;
    localparam logic [3:0] M_PT  = 4'b0010;
    localparam logic [3:0] M_RD  = 4'b0100;
    localparam logic [3:0] M_CNT = 4'b1000;
    localparam logic [3:0] M_ALL = 4'b1111;
    localparam logic [3:0] M_STD = 4'b1101;

    typedef struct {
        string       name;
        logic [3:0]  mask;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptgt;
        logic        rd;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are combinational on the current cycle, sampled at negedge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.mask[0]) begin
                vectors++;
                if (bus.o_fetch_pc !== e.pc) begin
                    miscompares++;
                    $display("FAIL %s fetch_pc got %h want %h", e.name, bus.o_fetch_pc, e.pc);
                end
            end
            if (e.mask[1]) begin
                vectors++;
                if (bus.o_pred_taken !== e.pt || bus.o_pred_target !== e.ptgt) begin
                    miscompares++;
                    $display("FAIL %s pred got %b/%h want %b/%h", e.name,
                             bus.o_pred_taken, bus.o_pred_target, e.pt, e.ptgt);
                end
            end
            if (e.mask[2]) begin
                vectors++;
                if (bus.o_redirect !== e.rd) begin
                    miscompares++;
                    $display("FAIL %s redirect got %b want %b", e.name, bus.o_redirect, e.rd);
                end
            end
            if (e.mask[3]) begin
                vectors++;
                if (bus.o_branch_count !== e.bc || bus.o_mispredict_count !== e.mc) begin
                    miscompares++;
                    $display("FAIL %s counts got %0d/%0d want %0d/%0d", e.name,
                             bus.o_branch_count, bus.o_mispredict_count, e.bc, e.mc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] mask,
                       input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                       input logic rd, input logic [31:0] bc, input logic [31:0] mc);
        exp_t e;
        e.name = name; e.mask = mask; e.pc = pc; e.pt = pt;
        e.ptgt = ptgt; e.rd = rd; e.bc = bc; e.mc = mc;
        q.push_back(e);
    endtask

    task automatic ex(input logic v, input logic [31:0] epc, input logic tk,
                      input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        bus.i_ex_valid_branch = v;
        bus.i_ex_pc           = epc;
        bus.i_ex_taken        = tk;
        bus.i_ex_target       = tgt;
        bus.i_ex_pred_taken   = ptk;
        bus.i_ex_pred_target  = ptgt;
    endtask

    task automatic ex_clr();
        ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.i_stall = 1'b0;
        bus.i_bp_predict_taken = 1'b0;
        ex_clr();
        tick();
        chk("reset", M_ALL, 32'h0, 1'b0, 32'h4, 1'b0, 0, 0);
        tick();

        rst = 1'b0;
        ex(1'b1, 32'h10, 1'b1, 32'h40, 1'b1, 32'h40);
        chk("pre_ok_branch", M_STD, 32'h0, 1'b0, 0, 1'b0, 0, 0);
        tick();
        ex(1'b0, 32'h20, 1'b1, 32'h80, 1'b0, 32'h0);
        chk("pre_invalid_ex", M_STD, 32'h4, 1'b0, 0, 1'b0, 1, 0);
        tick();
        ex_clr();
        chk("pre_seq8", M_STD, 32'h8, 1'b0, 0, 1'b0, 1, 0);
        tick();
        rst = 1'b1;
        #1;
        chk("async_rst", M_ALL, 32'h0, 1'b0, 32'h4, 1'b0, 0, 0);
        tick();

        rst = 1'b0;
        chk("seq0", M_STD, 32'h0, 1'b0, 0, 1'b0, 0, 0);
        tick();
        chk("seq4", M_STD, 32'h4, 1'b0, 0, 1'b0, 0, 0);
        tick();
        chk("seq8", M_STD, 32'h8, 1'b0, 0, 1'b0, 0, 0);
        tick();
        chk("seqC", M_STD, 32'hC, 1'b0, 0, 1'b0, 0, 0);
        tick();

        bus.i_bp_predict_taken = 1'b1;
        ex(1'b1, 32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
        chk("cold_miss", M_ALL, 32'h10, 1'b0, 32'h14, 1'b1, 0, 0);
        tick();
        bus.i_bp_predict_taken = 1'b0;
        ex_clr();
        chk("cold_redir", M_STD, 32'h40, 1'b0, 0, 1'b0, 1, 1);
        tick();
        ex(1'b1, 32'hC, 1'b0, 32'h0, 1'b1, 32'h80);
        chk("nt_redir_a", M_STD, 32'h44, 1'b0, 0, 1'b1, 1, 1);
        tick();

        bus.i_bp_predict_taken = 1'b1;
        ex_clr();
        chk("trained_hit", M_ALL, 32'h10, 1'b1, 32'h40, 1'b0, 2, 2);
        tick();
        bus.i_bp_predict_taken = 1'b0;
        ex(1'b1, 32'hC, 1'b0, 32'h0, 1'b1, 32'h80);
        chk("follow_pred", M_STD, 32'h40, 1'b0, 0, 1'b1, 2, 2);
        tick();
        ex_clr();
        chk("trained_dir0", M_ALL, 32'h10, 1'b0, 32'h14, 1'b0, 3, 3);
        tick();
        ex(1'b1, 32'h4C, 1'b0, 32'h0, 1'b1, 32'h80);
        chk("seq14", M_STD, 32'h14, 1'b0, 0, 1'b1, 3, 3);
        tick();

        bus.i_bp_predict_taken = 1'b1;
        ex_clr();
        chk("alias_miss", M_ALL, 32'h50, 1'b0, 32'h54, 1'b0, 4, 4);
        tick();
        bus.i_bp_predict_taken = 1'b0;
        bus.i_stall = 1'b1;
        ex(1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 32'h40);
        chk("stall_redir", M_STD, 32'h54, 1'b0, 0, 1'b1, 4, 4);
        tick();
        ex_clr();
        chk("stall_hold_a", M_STD, 32'h14, 1'b0, 0, 1'b0, 5, 5);
        tick();
        ex(1'b1, 32'hC, 1'b0, 32'h0, 1'b1, 32'h80);
        chk("stall_hold_b", M_STD, 32'h14, 1'b0, 0, 1'b1, 5, 5);
        tick();

        bus.i_stall = 1'b0;
        bus.i_bp_predict_taken = 1'b1;
        ex(1'b1, 32'h10, 1'b1, 32'h80, 1'b1, 32'h40);
        chk("btb_kept_wrong_tgt", M_ALL, 32'h10, 1'b1, 32'h40, 1'b1, 6, 6);
        tick();
        bus.i_bp_predict_taken = 1'b0;
        ex(1'b1, 32'hC, 1'b0, 32'h0, 1'b1, 32'h80);
        chk("tgt_redir", M_STD, 32'h80, 1'b0, 0, 1'b1, 7, 7);
        tick();
        bus.i_bp_predict_taken = 1'b1;
        ex_clr();
        chk("btb_new_tgt", M_ALL, 32'h10, 1'b1, 32'h80, 1'b0, 8, 8);
        tick();
        bus.i_bp_predict_taken = 1'b0;
        ex(1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 1'b1, 32'h80);
        chk("to_top", M_STD, 32'h80, 1'b0, 0, 1'b1, 8, 8);
        tick();

        bus.i_bp_predict_taken = 1'b1;
        ex_clr();
        chk("pc_wrap", M_ALL, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 9, 9);
        tick();
        bus.i_bp_predict_taken = 1'b0;
        ex(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h80);
        chk("expc_wrap", M_STD, 32'h0, 1'b0, 0, 1'b1, 9, 9);
        tick();
        ex(1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 32'h99);
        chk("nt_correct", M_STD, 32'h0, 1'b0, 0, 1'b0, 10, 10);
        tick();
        ex_clr();
        chk("final", M_STD, 32'h4, 1'b0, 0, 1'b0, 11, 10);
        tick();

        @(negedge clk);
        #1;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain queue got %0d want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
